// File: rtl/prod_accumulator.sv
// Block accumulator for a signed product stream: sums BLOCK_LEN beats (or fewer on in_last)
// and hands each block sum downstream. Define PROD_ACC_SAT_EN for saturating sums with sticky overflow.
module prod_accumulator #(
  parameter int NBIT      = 8,
  parameter int BLOCK_LEN = 4,
  parameter int ACC_W     = 2*NBIT + $clog2(BLOCK_LEN)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [2*NBIT-1:0]              in_data,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic [ACC_W-1:0]               out_data,
  output logic [$clog2(BLOCK_LEN+1)-1:0] out_cnt,
  output logic                           out_ovf,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int CNT_W = $clog2(BLOCK_LEN+1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_ACC  = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [ACC_W-1:0]   out_data_q;
  logic [CNT_W-1:0]   out_cnt_q;

  logic [ACC_W-1:0]   in_ext_s;
  logic [ACC_W-1:0]   sum_s;
  logic [ACC_W-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               accept_s;
  logic               close_s;

  assign in_ext_s = ACC_W'($signed(in_data));
  assign sum_s    = acc_q + in_ext_s;
  assign cnt_d    = cnt_q + CNT_W'(1);
  assign accept_s = in_valid && in_ready_q;
  assign close_s  = in_last || (cnt_d == CNT_W'(BLOCK_LEN));

`ifdef PROD_ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic ovf_q;
  logic out_ovf_q;
  logic beat_ovf_s;

  // Two same-signed addends producing a differently-signed sum is a signed overflow.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign beat_ovf_s = add_ovf(acc_q[ACC_W-1], in_ext_s[ACC_W-1], sum_s[ACC_W-1]);

  // Clamp to the rail on the side of the overflowing addends.
  always_comb begin
    acc_d = sum_s;
    if (beat_ovf_s) begin
      acc_d = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_d = sum_s;
    end
  end

  assign out_ovf = out_ovf_q;
`else
  assign acc_d   = sum_s;
  assign out_ovf = 1'b0;
`endif

  // Block FSM: INIT gives one dead cycle after reset, ACC sums beats, SEND holds the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
`ifdef PROD_ACC_SAT_EN
      ovf_q       <= 1'b0;
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_INIT: begin
          in_ready_q <= 1'b1;
          state_q    <= ST_ACC;
        end
        ST_ACC: begin
          if (accept_s) begin
            if (close_s) begin
              out_data_q  <= acc_d;
              out_cnt_q   <= cnt_d;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              acc_q       <= '0;
              cnt_q       <= '0;
`ifdef PROD_ACC_SAT_EN
              out_ovf_q   <= ovf_q | beat_ovf_s;
              ovf_q       <= 1'b0;
`endif
              state_q     <= ST_SEND;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_d;
`ifdef PROD_ACC_SAT_EN
              ovf_q <= ovf_q | beat_ovf_s;
`endif
            end
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_ACC;
          end
        end
        default: begin
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          state_q     <= ST_INIT;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// Bench for prod_accumulator: an 18-bit (default) and a 16-bit instance share one input stream;
// directed table rows plus random traffic are checked against a block-sum model.
module tb_prod_accumulator;

  localparam int BL = 4;

  typedef struct packed {
    logic [17:0] data;
    logic [2:0]  cnt;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [15:0] d [4];
    logic [3:0]  lmask;
    int          n;
    int          ed;
    int          ec;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;
  logic        in_ready18, in_ready16;
  logic [17:0] out_data18;
  logic [15:0] out_data16;
  logic [2:0]  out_cnt18, out_cnt16;
  logic        out_ovf18, out_ovf16;
  logic        out_valid18, out_valid16;

  int   checks = 0;
  int   errors = 0;
  bit   rnd_ready = 1'b0;
  int   blk[$];
  res_t exp18[$];
  res_t exp16[$];
  vec_t tbl[6];

  prod_accumulator #(.NBIT(8), .BLOCK_LEN(BL)) dut18 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready18), .out_data(out_data18), .out_cnt(out_cnt18), .out_ovf(out_ovf18),
    .out_valid(out_valid18), .out_ready(out_ready)
  );

  prod_accumulator #(.NBIT(8), .BLOCK_LEN(BL), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready16), .out_data(out_data16), .out_cnt(out_cnt16), .out_ovf(out_ovf16),
    .out_valid(out_valid16), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  // Block result from plain integer arithmetic: exact running sum, clamped or wrapped to w bits.
  function automatic res_t model_block(input int w);
    res_t        r;
    longint      s;
    longint      mx;
    longint      mn;
    logic        o;
    logic [17:0] m;
    s  = 0;
    o  = 1'b0;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -mx - 1;
    foreach (blk[i]) begin
      s = s + longint'(blk[i]);
`ifdef PROD_ACC_SAT_EN
      if (s > mx) begin
        s = mx;
        o = 1'b1;
      end else if (s < mn) begin
        s = mn;
        o = 1'b1;
      end
`endif
    end
    m = 18'((longint'(1) << w) - 1);
    r.data = 18'(s) & m;
    r.cnt  = 3'(blk.size());
    r.ovf  = o;
    return r;
  endfunction

  task automatic model_accept(input logic [15:0] d, input logic l);
    blk.push_back(int'($signed(d)));
    if (blk.size() == BL || l) begin
      exp18.push_back(model_block(18));
      exp16.push_back(model_block(16));
      blk.delete();
    end
  endtask

  // Presents one beat at posedge+2 and holds it until accepted; returns at posedge+2 after acceptance.
  task automatic beat(input logic [15:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready18;
      @(posedge clk);
      #2;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout got in_ready=0 expected 1 within 64 cycles");
    end else begin
      model_accept(d, l);
    end
    in_valid = 1'b0;
    in_data  = 16'h0000;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    blk.delete();
    exp18.delete();
    exp16.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic set_row(input int i, input int d0, input int d1, input int d2, input int d3,
                         input logic [3:0] lm, input int n, input int ed, input int ec);
    tbl[i].d[0]  = 16'(d0);
    tbl[i].d[1]  = 16'(d1);
    tbl[i].d[2]  = 16'(d2);
    tbl[i].d[3]  = 16'(d3);
    tbl[i].lmask = lm;
    tbl[i].n     = n;
    tbl[i].ed    = ed;
    tbl[i].ec    = ec;
  endtask

  // Random out_ready, driven off the sampling edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: every valid result must match the model queue head and stay stable until taken.
  initial begin
    bit   take_prev;
    res_t r;
    take_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        take_prev = 1'b0;
      end else begin
        if (take_prev) begin
          chk("valid_drop18", longint'(out_valid18), 0);
          chk("ready_back18", longint'(in_ready18), 1);
        end
        if (out_valid18) begin
          chk("ready_low18", longint'(in_ready18), 0);
          if (exp18.size() == 0) begin
            chk("spurious18", longint'(out_valid18), 0);
          end else begin
            r = exp18[0];
            chk("mon_data18", longint'(out_data18), longint'(r.data));
            chk("mon_cnt18", longint'(out_cnt18), longint'(r.cnt));
            chk("mon_ovf18", longint'(out_ovf18), longint'(r.ovf));
            if (out_ready) void'(exp18.pop_front());
          end
        end
        if (out_valid16) begin
          if (exp16.size() == 0) begin
            chk("spurious16", longint'(out_valid16), 0);
          end else begin
            r = exp16[0];
            chk("mon_data16", longint'(out_data16), longint'(r.data));
            chk("mon_cnt16", longint'(out_cnt16), longint'(r.cnt));
            chk("mon_ovf16", longint'(out_ovf16), longint'(r.ovf));
            if (out_ready) void'(exp16.pop_front());
          end
        end
        take_prev = out_valid18 && out_ready;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] e18;
    logic [15:0] e16;
    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000; in_last = 1'b0; out_ready = 1'b1;

    set_row(0, 100, 200, 300, 400, 4'b0000, 4, 1000, 4);
    set_row(1, 'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF, 4'b0000, 4, -4, 4);
    set_row(2, 7, 9, 0, 0, 4'b0010, 2, 16, 2);
    set_row(3, 5, 5, 5, 5, 4'b0000, 4, 20, 4);
    set_row(4, 'h7FFF, 'h7FFF, 'h7FFF, 'h7FFF, 4'b0000, 4, 'h1FFFC, 4);
    set_row(5, 42, 0, 0, 0, 4'b0001, 1, 42, 1);

    // Two reset cycles, then one dead cycle before in_ready rises.
    @(posedge clk); #2;
    @(negedge clk);
    chk("rst_in_ready", longint'(in_ready18), 0);
    chk("rst_out_valid", longint'(out_valid18), 0);
    chk("rst_out_data", longint'(out_data18), 0);
    chk("rst_out_cnt", longint'(out_cnt18), 0);
    chk("rst_out_ovf", longint'(out_ovf18), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("dead_cycle_ready", longint'(in_ready18), 0);
    @(posedge clk); #2;
    @(negedge clk);
    chk("ready_after_init", longint'(in_ready18), 1);
    @(posedge clk); #2;

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < tbl[i].n; j++) beat(tbl[i].d[j], tbl[i].lmask[j]);
      e18 = 18'(tbl[i].ed);
      @(negedge clk);
      chk("row_valid", longint'(out_valid18), 1);
      chk("row_data", longint'(out_data18), longint'(e18));
      chk("row_cnt", longint'(out_cnt18), longint'(tbl[i].ec));
      if (i == 4) begin
        chk("wide_ovf18", longint'(out_ovf18), 0);
`ifdef PROD_ACC_SAT_EN
        e16 = 16'h7FFF;
        chk("narrow_ovf16", longint'(out_ovf16), 1);
`else
        e16 = 16'hFFFC;
        chk("narrow_ovf16", longint'(out_ovf16), 0);
`endif
        chk("narrow_data16", longint'(out_data16), longint'(e16));
      end
      @(posedge clk); #2;
    end

    // Backpressure: result held for 10 cycles while an upstream beat waits unconsumed.
    out_ready = 1'b0;
    beat(16'd7, 1'b1);
    in_valid = 1'b1; in_data = 16'd99; in_last = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_valid", longint'(out_valid18), 1);
      chk("hold_data", longint'(out_data18), 7);
      chk("hold_ready", longint'(in_ready18), 0);
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    beat(16'd99, 1'b1);
    @(posedge clk); #2;

    // Reset mid-block discards the partial sum.
    beat(16'd3, 1'b0);
    beat(16'd3, 1'b0);
    do_reset();
    for (int j = 0; j < 4; j++) beat(16'd1, 1'b0);
    @(negedge clk);
    chk("post_rst_data", longint'(out_data18), 4);
    chk("post_rst_cnt", longint'(out_cnt18), 4);
    @(posedge clk); #2;

    // Reset mid-SEND discards the pending result.
    out_ready = 1'b0;
    beat(16'd50, 1'b1);
    @(posedge clk); #2;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_out_after_rst", longint'(out_valid18), 0);
      @(posedge clk); #2;
    end

    // Random traffic with gaps, early closes, extreme values and random backpressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [15:0] d;
      int          sel;
      repeat ($urandom_range(0, 2)) begin
        in_data = 16'($urandom);
        in_last = 1'($urandom_range(0, 1));
        @(posedge clk); #2;
      end
      sel = $urandom_range(0, 7);
      if (sel == 0) d = 16'h7FFF;
      else if (sel == 1) d = 16'h8000;
      else d = 16'($urandom);
      beat(d, 1'($urandom_range(0, 3) == 0));
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #2;
    end
    chk("drain18", longint'(exp18.size()), 0);
    chk("drain16", longint'(exp16.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
